mac_accum: RTL

- Sequential multiply-accumulate stage directly downstream of the operand multiplexors.
- Each cycle it consumes one signed operand pair, taken from mux_4/mux_2 outputs, over a valid/ready handshake.
- Accumulates iLen products into a wide accumulator, then presents the sum on a valid/ready output handshake.
- Sequences the Mac datapath: the operand muxes feed it, and the writeback logic consumes its result.

---
 rtl/mac_accum.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mac_accum.sv
// mac_accum: sequential multiply-accumulate stage.
// It accepts one signed operand pair per beat over a valid/ready handshake.
// After the programmed number of beats, it presents the accumulated sum on
// a valid/ready output handshake.
//
// Ports:
//   iClk, iReset      clock and synchronous active-high reset
//   iStart, iLen      job start pulse and beat count (acted on only in IDLE)
//   iValid, oReady    operand handshake; iOpA/iOpB sampled on accepted beats
//   oResult, oValid   accumulated sum and its valid flag
//   iReady            consumer accepts oResult
//   oBusy             high whenever the block is not IDLE
//   oOverflow         sticky signed-overflow flag for the current job
module mac_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 72,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic                        iStart,
  input  logic [LEN_WIDTH-1:0]        iLen,
  input  logic                        iValid,
  output logic                        oReady,
  input  logic signed [DATA_WIDTH-1:0] iOpA,
  input  logic signed [DATA_WIDTH-1:0] iOpB,
  output logic signed [ACC_WIDTH-1:0] oResult,
  output logic                        oValid,
  input  logic                        iReady,
  output logic                        oBusy,
  output logic                        oOverflow
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]        cnt;
  logic [LEN_WIDTH-1:0]        cnt_next;
  logic [LEN_WIDTH-1:0]        len;
  logic                        ovf;
  logic                        accept;

  logic signed [PROD_W-1:0]    prod_p1;
  logic                        vld_p1;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;

  // Two's-complement add that wraps modulo 2^ACC_WIDTH.
  function automatic logic signed [ACC_WIDTH-1:0] wrap_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // Signed overflow: the operands agree in sign but the sum does not.
  function automatic logic add_ovf(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b,
    input logic signed [ACC_WIDTH-1:0] s
  );
    return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  assign cnt_next = cnt + LEN_WIDTH'(1);
  assign accept   = iValid && oReady;
  assign prod_ext = ACC_WIDTH'(prod_p1);
  assign sum      = wrap_add(acc, prod_ext);

  assign oResult   = acc;
  assign oOverflow = ovf;

  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    oReady     = 1'b0;
    oValid     = 1'b0;
    oBusy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (iStart) state_next = (iLen == '0) ? DONE : RUN;
      end
      RUN: begin
        oReady = 1'b1;
        // The beat that completes the job moves straight to FLUSH.
        if (iValid && (cnt_next == len)) state_next = FLUSH;
      end
      FLUSH: begin
        state_next = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p1: register the full-width product of an accepted pair
  always_ff @(posedge iClk) begin
    if (iReset) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) prod_p1 <= iOpA * iOpB;
    end
  end

  // Stage p2: fold the registered product into the accumulator
  always_ff @(posedge iClk) begin
    if (iReset) begin
      acc <= '0;
      cnt <= '0;
      len <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && iStart) begin
        acc <= '0;
        cnt <= '0;
        len <= iLen;
        ovf <= 1'b0;
      end else begin
        if (vld_p1) begin
          acc <= sum;
          ovf <= ovf | add_ovf(acc, prod_ext, sum);
        end
        if (accept) cnt <= cnt_next;
      end
    end
  end

endmodule
